// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the zerocpu memory stage.
// Holds funct3 encodings, FSM states, the M->W bundle and a misalign helper.
package mem_stage_pkg;

   localparam int XLEN   = 64;
   localparam int MASK_W = XLEN / 8;

   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_D  = 3'b011;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;
   localparam logic [2:0] LS_WU = 3'b110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   typedef struct packed {
      logic            valid;
      logic            we;
      logic [4:0]      addr;
      logic [XLEN-1:0] data;
   } mw_t;

   // funct3[1:0] is the log2 access size for every load/store encoding,
   // including 111 which behaves as a doubleword.
   function automatic logic misaligned(
      input logic [2:0] off,
      input logic [1:0] sz
   );
      logic m;
      unique case (sz)
         2'd0:    m = 1'b0;
         2'd1:    m = off[0];
         2'd2:    m = |off[1:0];
         default: m = |off;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// mem_load_align: picks the load field at a byte offset and extends it.
// Ports: rdata (aligned doubleword), offset, funct3 -> data (XLEN).
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [2:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);

   logic [XLEN-1:0] sh;

   assign sh = rdata >> {offset, 3'b000};

   always_comb begin
      data = sh;
      case (funct3)
         LS_B:    data = {{56{sh[7]}}, sh[7:0]};
         LS_H:    data = {{48{sh[15]}}, sh[15:0]};
         LS_W:    data = {{32{sh[31]}}, sh[31:0]};
         LS_BU:   data = {56'd0, sh[7:0]};
         LS_HU:   data = {48'd0, sh[15:0]};
         LS_WU:   data = {32'd0, sh[31:0]};
         default: data = sh;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: M stage; runs dmem req/rsp, aligns loads, registers M->W.
// Ports: M inputs, dmem_* bus, stallM, misalignM, W outputs; MEM_STAGE_PERF_EN adds counters.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              validM,
   input  logic [XLEN-1:0]   aluOutM,
   input  logic [XLEN-1:0]   storeDataM,
   input  logic              memReadM,
   input  logic              memWriteM,
   input  logic [2:0]        memSizeM,
   input  logic              rdWriteEnableM,
   input  logic [4:0]        rdWriteAddrM,
   output logic              dmem_req_valid,
   input  logic              dmem_req_ready,
   output logic              dmem_we,
   output logic [XLEN-1:0]   dmem_addr,
   output logic [XLEN-1:0]   dmem_wdata,
   output logic [MASK_W-1:0] dmem_wmask,
   input  logic              dmem_rsp_valid,
   input  logic [XLEN-1:0]   dmem_rdata,
   output logic              stallM,
   output logic              misalignM,
   output logic              validW,
   output logic              rdWriteEnableW,
   output logic [4:0]        rdWriteAddrW,
`ifdef MEM_STAGE_PERF_EN
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_memop_cnt,
`endif
   output logic [XLEN-1:0]   rdWriteDataW
);

   state_t          state, nxt;
   logic            memop, mis;
   logic            req, stall, done, mis_flag;
   logic [XLEN-1:0] ld_data;
   logic [7:0]      base_mask;
   mw_t             wb, wb_nxt;

   assign memop = validM & (memReadM | memWriteM);
   assign mis   = misaligned(aluOutM[2:0], memSizeM[1:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt      = state;
      req      = 1'b0;
      stall    = 1'b0;
      done     = 1'b0;
      mis_flag = 1'b0;
      case (state)
         IDLE: begin
            if (memop) begin
               if (mis) begin
                  mis_flag = 1'b1;
               end else begin
                  req   = 1'b1;
                  stall = 1'b1;
                  nxt   = dmem_req_ready ? WAIT : REQ;
               end
            end
         end
         REQ: begin
            req   = 1'b1;
            stall = 1'b1;
            if (dmem_req_ready) nxt = WAIT;
         end
         WAIT: begin
            if (dmem_rsp_valid) begin
               done = 1'b1;
               nxt  = IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   // Combinational outputs stay low while reset is held.
   assign stallM         = stall & ~rst;
   assign dmem_req_valid = req & ~rst;
   assign misalignM      = mis_flag & ~rst;

   always_comb begin
      case (memSizeM[1:0])
         2'd0:    base_mask = 8'h01;
         2'd1:    base_mask = 8'h03;
         2'd2:    base_mask = 8'h0F;
         default: base_mask = 8'hFF;
      endcase
   end

   assign dmem_we    = dmem_req_valid & memWriteM;
   assign dmem_addr  = dmem_req_valid ?
                       {aluOutM[XLEN-1:3], 3'b000} : '0;
   assign dmem_wdata = dmem_we ?
                       storeDataM << {aluOutM[2:0], 3'b000} : '0;
   assign dmem_wmask = dmem_we ?
                       base_mask << aluOutM[2:0] : '0;

   mem_load_align u_align (
      .rdata  (dmem_rdata),
      .offset (aluOutM[2:0]),
      .funct3 (memSizeM),
      .data   (ld_data)
   );

   always_comb begin
      wb_nxt.valid = validM;
      wb_nxt.we    = rdWriteEnableM & validM;
      wb_nxt.addr  = rdWriteAddrM;
      wb_nxt.data  = aluOutM;
      unique case (1'b1)
         stall | mis_flag: begin
            wb_nxt.valid = 1'b0;
            wb_nxt.we    = 1'b0;
         end
         done: begin
            wb_nxt.we = rdWriteEnableM & ~memWriteM;
            if (!memWriteM) wb_nxt.data = ld_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wb <= '0;
      else     wb <= wb_nxt;
   end

   assign validW         = wb.valid;
   assign rdWriteEnableW = wb.we;
   assign rdWriteAddrW   = wb.addr;
   assign rdWriteDataW   = wb.data;

`ifdef MEM_STAGE_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt <= '0;
         perf_memop_cnt <= '0;
      end else begin
         if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (done)  perf_memop_cnt <= perf_memop_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage.
// A driver issues ops and pushes expectations; a monitor pops on validW.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 0;
   logic        rst;
   logic        validM;
   logic [63:0] aluOutM, storeDataM;
   logic        memReadM, memWriteM;
   logic [2:0]  memSizeM;
   logic        rdWriteEnableM;
   logic [4:0]  rdWriteAddrM;
   logic        dmem_req_valid, dmem_req_ready, dmem_we;
   logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [7:0]  dmem_wmask;
   logic        dmem_rsp_valid;
   logic        stallM, misalignM;
   logic        validW, rdWriteEnableW;
   logic [4:0]  rdWriteAddrW;
   logic [63:0] rdWriteDataW;

   typedef struct {
      logic [4:0]  addr;
      logic        we;
      logic [63:0] data;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk            (clk),
      .rst            (rst),
      .validM         (validM),
      .aluOutM        (aluOutM),
      .storeDataM     (storeDataM),
      .memReadM       (memReadM),
      .memWriteM      (memWriteM),
      .memSizeM       (memSizeM),
      .rdWriteEnableM (rdWriteEnableM),
      .rdWriteAddrM   (rdWriteAddrM),
      .dmem_req_valid (dmem_req_valid),
      .dmem_req_ready (dmem_req_ready),
      .dmem_we        (dmem_we),
      .dmem_addr      (dmem_addr),
      .dmem_wdata     (dmem_wdata),
      .dmem_wmask     (dmem_wmask),
      .dmem_rsp_valid (dmem_rsp_valid),
      .dmem_rdata     (dmem_rdata),
      .stallM         (stallM),
      .misalignM      (misalignM),
      .validW         (validW),
      .rdWriteEnableW (rdWriteEnableW),
      .rdWriteAddrW   (rdWriteAddrW),
      .rdWriteDataW   (rdWriteDataW)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic int nbytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic [63:0] ref_load(input logic [63:0] rd,
                                           input int off,
                                           input logic [2:0] f3);
      int          n;
      logic [63:0] v, m;
      n = nbytes(f3);
      v = rd >> (8 * off);
      m = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 1);
      v = v & m;
      if (f3 <= 3'd2 && v[8*n-1]) v = v | ~m;
      return v;
   endfunction

   // Monitor: every cycle the W bundle is valid it must match the queue head.
   always @(negedge clk) begin
      if (!rst && validW) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wb_unexpected actual=%h expected=none",
                     rdWriteDataW);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("wb_addr", 64'(rdWriteAddrW), 64'(e.addr));
            chk("wb_we", 64'(rdWriteEnableW), 64'(e.we));
            chk("wb_data", rdWriteDataW, e.data);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic v, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] sd, input logic rwe,
                         input logic [4:0] rwa, input int rdy_dly,
                         input int rsp_dly, input logic [63:0] rdata);
      int          n, off, stalls;
      logic        memop, mis, acc;
      logic [63:0] xmask, xwdata;
      exp_t        e;
      off   = int'(addr[2:0]);
      memop = v && (rd || wr);
      mis   = memop && ((addr % 64'(nbytes(f3))) != 0);
      validM         = v;
      memReadM       = rd;
      memWriteM      = wr;
      memSizeM       = f3;
      aluOutM        = addr;
      storeDataM     = sd;
      rdWriteEnableM = rwe;
      rdWriteAddrM   = rwa;
      dmem_rsp_valid = 0;
      dmem_req_ready = 0;
      if (v && !mis) begin
         e.addr = rwa;
         e.we   = memop ? (wr ? 1'b0 : rwe) : rwe;
         e.data = (memop && !wr) ? ref_load(rdata, off, f3) : addr;
         sbq.push_back(e);
      end
      if (!memop || mis) begin
         @(negedge clk);
         chk("plain_stall", 64'(stallM), 64'd0);
         chk("plain_misalign", 64'(misalignM), 64'(mis));
         chk("plain_req", 64'(dmem_req_valid), 64'd0);
         step();
         return;
      end
      xmask  = wr ? 64'(((1 << nbytes(f3)) - 1) << off) : 64'd0;
      xwdata = wr ? (sd << (8 * off)) : 64'd0;
      stalls = 0;
      n      = 0;
      acc    = 0;
      while (!acc) begin
         dmem_req_ready = (n >= rdy_dly);
         dmem_rsp_valid = (n < rdy_dly) ? 1'($urandom) : 1'b0;
         dmem_rdata     = {$urandom, $urandom};
         @(negedge clk);
         chk("req_valid", 64'(dmem_req_valid), 64'd1);
         chk("req_addr", dmem_addr, {addr[63:3], 3'b000});
         chk("req_we", 64'(dmem_we), 64'(wr));
         chk("req_mask", 64'(dmem_wmask), xmask);
         chk("req_wdata", dmem_wdata, xwdata);
         if (stallM) stalls++;
         acc = dmem_req_ready;
         step();
         n++;
         if (n > 40) begin
            checks++;
            errors++;
            $display("FAIL req_timeout actual=%0d expected=%0d", n, rdy_dly);
            return;
         end
      end
      for (int w = 0; w <= rsp_dly; w++) begin
         dmem_req_ready = 1'($urandom);
         dmem_rsp_valid = (w == rsp_dly);
         dmem_rdata     = (w == rsp_dly) ? rdata : {$urandom, $urandom};
         @(negedge clk);
         chk("wait_req", 64'(dmem_req_valid), 64'd0);
         chk("wait_stall", 64'(stallM), 64'(w != rsp_dly));
         if (stallM) stalls++;
         step();
      end
      dmem_rsp_valid = 0;
      chk("stall_cycles", 64'(stalls), 64'(rdy_dly + 1 + rsp_dly));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1;
      validM = 0; memReadM = 0; memWriteM = 0; memSizeM = 0;
      aluOutM = 0; storeDataM = 0; rdWriteEnableM = 0; rdWriteAddrM = 0;
      dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_validW", 64'(validW), 64'd0);
      chk("rst_weW", 64'(rdWriteEnableW), 64'd0);
      chk("rst_dataW", rdWriteDataW, 64'd0);
      chk("rst_stall", 64'(stallM), 64'd0);
      rst = 0;
      step();

      run_op(1, 0, 0, 3'b000, 64'h1234, 0, 1, 5, 0, 0, 0);
      run_op(1, 1, 0, LS_B, 64'h1003, 0, 1, 7, 0, 0,
             64'h0000_0000_8000_0000);
      run_op(1, 1, 0, LS_WU, 64'h2004, 0, 1, 9, 3, 2,
             64'hDEAD_BEEF_0000_0000);
      run_op(1, 0, 1, LS_H, 64'h3006, 64'hABCD, 1, 3, 0, 0, 0);
      run_op(1, 1, 0, LS_W, 64'h4002, 0, 1, 4, 0, 0, 0);
      run_op(0, 1, 0, LS_D, 64'h5000, 0, 1, 6, 0, 0, 0);

      for (int i = 0; i < 200; i++) begin
         logic        v, rd, wr;
         logic [2:0]  f3;
         logic [63:0] a;
         int          k;
         v  = ($urandom % 8) != 0;
         k  = $urandom % 3;
         rd = (k == 1) || (k == 2 && ($urandom % 8) == 0);
         wr = (k == 2);
         f3 = wr ? 3'($urandom % 4) : 3'($urandom % 8);
         a  = {$urandom, $urandom};
         if ($urandom % 4 != 0) a = a & ~64'(nbytes(f3) - 1);
         run_op(v, rd, wr, f3, a, {$urandom, $urandom}, 1'($urandom),
                5'($urandom), $urandom % 4, $urandom % 4,
                {$urandom, $urandom});
      end

      // Reset while a load is waiting for its response.
      validM = 1; memReadM = 1; memWriteM = 0; memSizeM = LS_D;
      aluOutM = 64'h6000; rdWriteEnableM = 1; rdWriteAddrM = 5'd11;
      dmem_req_ready = 1; dmem_rsp_valid = 0;
      step();
      dmem_req_ready = 0;
      rst = 1;
      validM = 0; memReadM = 0;
      @(negedge clk);
      chk("mid_rst_stall", 64'(stallM), 64'd0);
      chk("mid_rst_req", 64'(dmem_req_valid), 64'd0);
      chk("mid_rst_validW", 64'(validW), 64'd0);
      chk("mid_rst_dataW", rdWriteDataW, 64'd0);
      step();
      rst = 0;
      step();
      dmem_rsp_valid = 1;
      dmem_rdata = 64'h1111_2222_3333_4444;
      @(negedge clk);
      chk("late_rsp_stall", 64'(stallM), 64'd0);
      step();
      dmem_rsp_valid = 0;
      @(negedge clk);
      chk("late_rsp_validW", 64'(validW), 64'd0);
      chk("late_rsp_weW", 64'(rdWriteEnableW), 64'd0);
      step();

      chk("sb_empty", 64'(sbq.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the zerocpu 5-stage RV64 pipeline; sits directly downstream of the execute stage.
- Consumes the ALU result, store data and the M-side writeback controls, and runs a valid/ready request plus response transaction to data memory for loads and stores.
- Aligns and sign/zero-extends load data, stalls the pipeline while an access is outstanding, and registers the M->W writeback bundle.

Parameters:
- XLEN, 64, datapath width (matches `DATA_BUS`).
- MASK_W, XLEN/8, byte-mask width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- validM  in  1  instruction in M is real (not a bubble)
- aluOutM  in  XLEN  ALU result / effective address
- storeDataM  in  XLEN  rs2 value for stores
- memReadM  in  1  load
- memWriteM  in  1  store
- memSizeM  in  3  RISC-V funct3 of the load/store
- rdWriteEnableM  in  1  writeback enable from EX
- rdWriteAddrM  in  5  destination register
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_we  out  1  1 = store
- dmem_addr  out  XLEN  doubleword-aligned address {aluOutM[63:3],3'b0}
- dmem_wdata  out  XLEN  store data, shifted to byte lane
- dmem_wmask  out  MASK_W  byte enables
- dmem_rsp_valid  in  1  response (load data or store ack)
- dmem_rdata  in  XLEN  aligned doubleword read data
- stallM  out  1  hold EX/M and all upstream stages
- misalignM  out  1  one-cycle misaligned-access flag
- validW, rdWriteEnableW  out  1 each  registered writeback controls
- rdWriteAddrW  out  5  registered destination register
- rdWriteDataW  out  XLEN  registered writeback data

Behaviour:
- Reset: asynchronous and active-high; clk is the only clock. All registered outputs (validW, rdWriteEnableW, rdWriteAddrW, rdWriteDataW) reset to 0, FSM resets to IDLE, and stallM, dmem_req_valid and misalignM are 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE, no memory op (validM=0, or memRead=memWrite=0):
  - stallM=0.
  - At the next edge the W registers capture validM, rdWriteEnableM&validM, rdWriteAddrM, and aluOutM.
  - Latency is 1 cycle.
- IDLE, aligned memory op:
  - dmem_req_valid=1 and stallM=1 combinationally in that cycle.
  - ready=1 -> WAIT; ready=0 -> REQ.
- REQ: hold dmem_req_valid=1 with stable addr/wdata/mask/we until ready=1, then -> WAIT. stallM=1.
- WAIT:
  - stallM=1 until the cycle dmem_rsp_valid=1. In that cycle stallM=0.
  - At that edge the W registers capture the result and the FSM -> IDLE.
  - Load data = aligned/extended dmem_rdata. Store data = aluOutM, with rdWriteEnableW forced to 0.
- Response timing: the earliest response is the cycle after acceptance, so the minimum memory-op latency is 2 cycles. A rsp_valid in the same cycle as acceptance is illegal.
- While stallM=1, the W registers load a bubble (validW=0, rdWriteEnableW=0). Upstream holds the M inputs stable.
- Misaligned access: misaligned means the address is not a multiple of the access size (H: addr[0]; W: addr[1:0]; D: addr[2:0]).
  - No request is issued and stallM=0.
  - misalignM=1 for that cycle, and W captures a bubble.
- Load funct3 mapping:
  - 000 LB, 001 LH, 010 LW, 011 LD: sign-extend.
  - 100 LBU, 101 LHU, 110 LWU: zero-extend.
  - The field is selected from dmem_rdata by byte offset aluOutM[2:0].
  - 111 is treated as LD.
- Store funct3 000/001/010/011:
  - wmask is 0x01/0x03/0x0F/0xFF shifted left by the offset.
  - wdata is storeDataM shifted left by 8*offset.
- Simultaneous memRead and memWrite is illegal; memWrite takes priority.
- When no request is active, dmem outputs are driven to 0.
- Reset mid-transaction returns the FSM to IDLE immediately. A dmem_rsp_valid arriving while in IDLE or REQ is ignored.

Optional Feature:
- Macro: MEM_STAGE_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt [31:0], incremented every cycle stallM=1, wrapping at 2^32.
  - Adds output perf_memop_cnt [31:0], incremented on each dmem_rsp_valid consumed in WAIT.
  - Both counters reset to 0.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- defines.v additions:
  - funct3 encodings (`LS_B`, `LS_H`, `LS_W`, `LS_D`, `LS_BU`, `LS_HU`, `LS_WU`).
  - FSM state encodings (2 bits).
  - `MASK_BUS`.
- W registers reuse the existing DFF primitive, one instance per field.
- One combinational sub-module: mem_load_align (inputs rdata, offset, funct3; output extended XLEN data). Store lane shifting stays inline.

Test Plan:
- Non-mem op: aluOutM=0x1234, rdWriteEnableM=1, rdWriteAddrM=5 -> next cycle rdWriteDataW=0x1234, rdWriteAddrW=5, stallM never 1.
- LB at 0x1003, ready=1, rsp one cycle later with rdata=0x00000000_80000000 -> stallM=1 for 1 cycle, dmem_addr=0x1000, rdWriteDataW=0xFFFFFFFF_FFFFFF80.
- LWU at 0x2004, ready=0 for 3 cycles, then rsp after 2 more cycles with rdata=0xDEADBEEF_00000000 -> request held stable, stallM=1 for 6 cycles, rdWriteDataW=0x00000000_DEADBEEF.
- SH at 0x3006, storeDataM=0xABCD -> wmask=0xC0, wdata=0xABCD_0000_0000_0000, dmem_we=1, rdWriteEnableW=0.
- LW at 0x4002 -> misalignM=1 for one cycle, dmem_req_valid=0, stallM=0, validW=0.
- rst asserted in WAIT -> all outputs 0, state IDLE; a later rsp_valid has no effect.
